// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/fulladder_HA.sv
// Single-bit full-adder cell built from two half-adder stages.
module fulladder_HA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sout = p ^ cin;
  assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock, through a
// single full-adder cell with a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_sout, fa_cout;

  fulladder_HA u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sout (fa_sout),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // New bit enters at the MSB so bit 0 settles at sum[0] after WIDTH shifts.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_sout) << (WIDTH - 1));
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 3 and 1 against an arithmetic timing model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int nchk = 0;
  int nerr = 0;
  int widths[3] = '{8, 3, 1};

  // Model: age = edges since the accepting edge (0 = idle); res = full a+b+cin of the
  // operation in flight; held = the result visible while not busy.
  int          age[3];
  logic [63:0] res[3];
  logic [63:0] held[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic st, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci);
    case (i)
      0:       begin start8 = st; a8 = av;      b8 = bv;      cin8 = ci; end
      1:       begin start3 = st; a3 = av[2:0]; b3 = bv[2:0]; cin3 = ci; end
      default: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; cin1 = ci; end
    endcase
  endtask

  function automatic logic get_busy(input int i);
    case (i)
      0:       return busy8;
      1:       return busy3;
      default: return busy1;
    endcase
  endfunction

  function automatic logic get_done(input int i);
    case (i)
      0:       return done8;
      1:       return done3;
      default: return done1;
    endcase
  endfunction

  function automatic logic get_cout(input int i);
    case (i)
      0:       return cout8;
      1:       return cout3;
      default: return cout1;
    endcase
  endfunction

  function automatic logic [7:0] get_sum(input int i);
    case (i)
      0:       return sum8;
      1:       return {5'd0, sum3};
      default: return {7'd0, sum1};
    endcase
  endfunction

  task automatic model_step(input int i, input logic st, input logic [63:0] av,
                            input logic [63:0] bv, input logic ci);
    int w;
    w = widths[i];
    if (!rst_n) begin
      age[i]  = 0;
      held[i] = '0;
    end else if ((age[i] == 0 || age[i] == w + 1) && st) begin
      age[i]  = 1;
      res[i]  = av + bv + {63'd0, ci};
      held[i] = '0;
    end else if (age[i] >= 1 && age[i] <= w) begin
      age[i]++;
      if (age[i] == w + 1) held[i] = res[i];
    end else begin
      age[i] = 0;
    end
  endtask

  task automatic check_model(input int i);
    int          w, k;
    logic [63:0] es, mask;
    logic        ec, bz_exp, dn_exp;
    w      = widths[i];
    mask   = (64'd1 << w) - 64'd1;
    bz_exp = (age[i] >= 1 && age[i] <= w);
    dn_exp = (age[i] == w + 1);
    if (bz_exp) begin
      // k bits done: the low k result bits sit at the top of the sum register.
      k  = age[i] - 1;
      es = (res[i] & ((64'd1 << k) - 64'd1)) << (w - k);
      ec = 1'b0;
    end else begin
      es = held[i] & mask;
      ec = held[i][w];
    end
    chk($sformatf("w%0d_model_busy", w), 64'(get_busy(i)), 64'(bz_exp));
    chk($sformatf("w%0d_model_done", w), 64'(get_done(i)), 64'(dn_exp));
    chk($sformatf("w%0d_model_sum", w), 64'(get_sum(i)), es);
    chk($sformatf("w%0d_model_cout", w), 64'(get_cout(i)), 64'(ec));
  endtask

  always @(posedge clk) begin
    model_step(0, start8, {56'd0, a8}, {56'd0, b8}, cin8);
    model_step(1, start3, {61'd0, a3}, {61'd0, b3}, cin3);
    model_step(2, start1, {63'd0, a1}, {63'd0, b1}, cin1);
    #1;
    for (int i = 0; i < 3; i++) check_model(i);
  end

  // One operation with literal expectations; optional re-pulse of start during RUN.
  task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic [7:0] es, input logic ec, input int repulse);
    int   n     = 0;
    int   nbusy = 0;
    int   w     = widths[i];
    logic seen  = 1'b0;
    @(negedge clk);
    drive(i, 1'b1, av, bv, ci);
    while (!seen && n < 4 * w + 8) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) drive(i, 1'b0, ~av, ~bv, ~ci);
      if (repulse >= 0 && n == repulse + 1) drive(i, 1'b1, 8'hFF, 8'hFF, 1'b1);
      if (repulse >= 0 && n == repulse + 2) drive(i, 1'b0, ~av, ~bv, ~ci);
      if (get_busy(i)) nbusy++;
      seen = get_done(i);
    end
    chk($sformatf("w%0d_done_seen", w), 64'(seen), 64'd1);
    chk($sformatf("w%0d_latency", w), 64'(n), 64'(w + 1));
    chk($sformatf("w%0d_busy_cycles", w), 64'(nbusy), 64'(w));
    chk($sformatf("w%0d_sum_%0h_%0h_%0b", w, av, bv, ci), 64'(get_sum(i)), 64'(es));
    chk($sformatf("w%0d_cout_%0h_%0h_%0b", w, av, bv, ci), 64'(get_cout(i)), 64'(ec));
    @(posedge clk);
    #1;
    chk($sformatf("w%0d_done_one_cycle", w), 64'(get_done(i)), 64'd0);
    chk($sformatf("w%0d_idle_after_done", w), 64'(get_busy(i)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    run_op(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
    run_op(0, 8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, -1);
    run_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);

    // start held high: back-to-back results every 9 edges.
    @(negedge clk);
    drive(0, 1'b1, 8'h10, 8'h20, 1'b0);
    n  = 0;
    nd = 0;
    while (n < 27) begin
      @(posedge clk);
      n++;
      #1;
      if (done8) begin
        nd++;
        chk("held_done_pos", 64'(n), 64'(9 * nd));
        chk("held_sum", 64'(sum8), 64'h30);
        chk("held_cout", 64'(cout8), 64'd0);
      end
    end
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("held_done_count", 64'(nd), 64'd3);

    // Reset asserted mid-RUN after four bits have been processed.
    @(negedge clk);
    drive(0, 1'b1, 8'hFF, 8'h00, 1'b0);
    n = 0;
    while (n < 5) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    chk("pre_rst_busy", 64'(busy8), 64'd1);
    chk("pre_rst_partial_sum", 64'(sum8), 64'hF0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_sum", 64'(sum8), 64'd0);
    chk("midrst_cout", 64'(cout8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, -1);

    // WIDTH=3 exhaustive sweep.
    for (int ab = 0; ab < 64; ab++) begin
      for (int c = 0; c < 2; c++) begin
        int tot;
        tot = (ab & 7) + (ab >> 3) + c;
        run_op(1, 8'(ab & 7), 8'(ab >> 3), 1'(c), 8'(tot & 7), 1'(tot >> 3), -1);
      end
    end

    // WIDTH=1 smoke test.
    run_op(2, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, -1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
